// File: rtl/t_ff.sv
// t_ff: WIDTH-bit toggle flip-flop with complementary output.
// Define T_FF_RESET_HIGH_EN to make the reset value all ones instead of all zeros.
module t_ff #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  input  logic [WIDTH-1:0] t,
  input  logic             clk,
  input  logic             reset
);

`ifdef T_FF_RESET_HIGH_EN
  localparam logic [WIDTH-1:0] RST_VAL = '1;
`else
  localparam logic [WIDTH-1:0] RST_VAL = '0;
`endif

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  // Each bit flips independently where its toggle enable is set.
  always_comb begin
    w_q_nxt = r_q ^ t;
  end

  // Toggle state; the async reset wins over any coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: tb/tb_t_ff.sv
// tb_t_ff: directed bench for t_ff, 1-bit and 4-bit instances.
// Reset value follows T_FF_RESET_HIGH_EN.
module tb_t_ff;

`ifdef T_FF_RESET_HIGH_EN
  localparam logic [3:0] RV4 = 4'b1111;
  localparam logic       RV1 = 1'b1;
`else
  localparam logic [3:0] RV4 = 4'b0000;
  localparam logic       RV1 = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       t1;
  logic       q1;
  logic       qb1;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qb4;

  int checks = 0;
  int errors = 0;

  t_ff #(.WIDTH(1)) u_dut1 (
    .q     (q1),
    .qb    (qb1),
    .t     (t1),
    .clk   (clk),
    .reset (reset)
  );

  t_ff #(.WIDTH(4)) u_dut4 (
    .q     (q4),
    .qb    (qb4),
    .t     (t4),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic exp);
    chk({tag, ".q"}, {3'b000, q1}, {3'b000, exp});
    chk({tag, ".qb"}, {3'b000, qb1}, {3'b000, ~exp});
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp);
    chk({tag, ".q4"}, q4, exp);
    chk({tag, ".qb4"}, qb4, ~exp);
  endtask

  initial begin
    reset = 1'b0;
    t1    = 1'b1;
    t4    = 4'b0000;

    // 6 ns: reset held through the 5 ns edge with t=1
    #6;
    chk1("rst_edge5", RV1);
    chk4("rst_edge5", RV4);

    // 12 ns: release reset
    #6;
    reset = 1'b1;

    // 16/26/36 ns: toggling every edge
    #4;
    chk1("tog15", ~RV1);
    chk4("hold15", RV4);
    #10;
    chk1("tog25", RV1);
    #10;
    chk1("tog35", ~RV1);
    t1 = 1'b0;

    // 46/56/66 ns: hold with t=0
    #10;
    chk1("hold45", ~RV1);
    #10;
    chk1("hold55", ~RV1);
    #10;
    chk1("hold65", ~RV1);

    // 67 ns: async reset between edges
    #1;
    reset = 1'b0;
    t1    = 1'b1;
    #1;
    chk1("async_rst", RV1);
    chk4("async_rst", RV4);

    // 76 ns: reset dominates the 75 ns edge
    #8;
    chk1("rst_edge75", RV1);

    // 77 ns: release; first toggle at 85 ns
    #1;
    reset = 1'b1;
    #9;
    chk1("tog85", ~RV1);
    chk4("hold85", RV4);
    t1 = 1'b0;
    t4 = 4'b0101;

    // t pulse between edges must be ignored
    #2;
    t1 = 1'b1;
    #4;
    t1 = 1'b0;

    // 96 ns: mid-cycle t pulse ignored, 4-bit pattern toggles
    #4;
    chk1("glitch95", ~RV1);
    chk4("w4_95", RV4 ^ 4'b0101);

    // 106 ns: second toggle restores
    #10;
    chk4("w4_105", RV4);
    t4 = 4'b1100;

    // 116 ns: different pattern
    #10;
    chk4("w4_115", RV4 ^ 4'b1100);
    t4 = 4'b0000;

    // 126 ns: hold on the wide instance
    #10;
    chk4("w4_hold125", RV4 ^ 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
